// File: rtl/viterbi_ber_checker.sv
// BER checker for the Viterbi test harness: searches the source-bit history for the
// encoder/channel/decoder latency, then counts decoded bits and bit errors once aligned.
module viterbi_ber_checker #(
   parameter int MAX_LAT    = 64,
   parameter int WIN        = 32,
   parameter int LOCK_ERR   = 2,
   parameter int UNLOCK_ERR = 8,
   parameter int CW         = 16,
   localparam int LW        = $clog2(MAX_LAT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ref_valid_i,
   input  logic          ref_bit_i,
   input  logic          dec_valid_i,
   input  logic          dec_bit_i,
   input  logic          clear_i,
   output logic          locked_o,
   output logic [LW-1:0] latency_o,
   output logic [CW-1:0] bit_ct_o,
   output logic [CW-1:0] err_ct_o,
   output logic          sat_o
);
   localparam int FW = $clog2(MAX_LAT + 1);
   localparam int SW = $clog2(WIN);
   localparam int EW = $clog2(WIN + 1);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t              state;
   logic [MAX_LAT-1:0]  hist;
   logic [FW-1:0]       fill;
   logic [SW-1:0]       samp_ct;
   logic [EW-1:0]       win_err;

   logic          usable, mis, win_end;
   logic [EW-1:0] win_tot;
   logic [LW-1:0] lat_next;
   logic [CW-1:0] bit_inc, err_inc;

   // A sample is only meaningful once the history reaches back far enough.
   assign usable   = dec_valid_i && (fill > FW'(latency_o));
   assign mis      = dec_bit_i ^ hist[latency_o];
   assign win_end  = usable && (samp_ct == SW'(WIN - 1));
   assign win_tot  = win_err + EW'(mis);
   assign lat_next = (latency_o == LW'(MAX_LAT - 1)) ? '0 : latency_o + 1'b1;
   assign bit_inc  = (bit_ct_o == '1) ? bit_ct_o : bit_ct_o + 1'b1;
   assign err_inc  = (err_ct_o == '1) ? err_ct_o : err_ct_o + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEARCH;
         hist      <= '0;
         fill      <= '0;
         samp_ct   <= '0;
         win_err   <= '0;
         locked_o  <= 1'b0;
         latency_o <= '0;
         bit_ct_o  <= '0;
         err_ct_o  <= '0;
         sat_o     <= 1'b0;
      end else begin
         // Comparison above uses pre-shift history; shift afterwards.
         if (ref_valid_i) begin
            hist <= {hist[MAX_LAT-2:0], ref_bit_i};
            if (fill != FW'(MAX_LAT)) fill <= fill + 1'b1;
         end

         if (usable) begin
            if (win_end) begin
               samp_ct <= '0;
               win_err <= '0;
               case (state)
                  SEARCH: begin
                     if (win_tot <= EW'(LOCK_ERR)) begin
                        state    <= LOCKED;
                        locked_o <= 1'b1;
                     end else begin
                        latency_o <= lat_next;
                     end
                  end
                  LOCKED: begin
                     if (win_tot >= EW'(UNLOCK_ERR)) begin
                        state     <= SEARCH;
                        locked_o  <= 1'b0;
                        latency_o <= lat_next;
                     end
                  end
                  default: state <= SEARCH;
               endcase
            end else begin
               samp_ct <= samp_ct + 1'b1;
               win_err <= win_tot;
            end
         end

         // Clear beats a coincident counted sample; the window still sees it.
         if (clear_i) begin
            bit_ct_o <= '0;
            err_ct_o <= '0;
            sat_o    <= 1'b0;
         end else if (state == LOCKED && usable) begin
            bit_ct_o <= bit_inc;
            if (mis) err_ct_o <= err_inc;
            if (bit_inc == '1 || (mis && err_inc == '1)) sat_o <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Scoreboard bench: a reference model computes expected outputs per cycle for a CW=16
// and a CW=4 instance fed the same stimulus, plus directed checks at key points.
module tb_viterbi_ber_checker;
   logic clk = 1'b0;
   logic rst, ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i, clear_i;
   logic        locked_a, locked_b, sat_a, sat_b;
   logic [5:0]  lat_a, lat_b;
   logic [15:0] bit_a, err_a;
   logic [3:0]  bit_b, err_b;

   viterbi_ber_checker #(.CW(16)) dut_a (
      .clk(clk), .rst(rst), .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
      .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i), .clear_i(clear_i),
      .locked_o(locked_a), .latency_o(lat_a), .bit_ct_o(bit_a), .err_ct_o(err_a), .sat_o(sat_a));

   viterbi_ber_checker #(.CW(4)) dut_b (
      .clk(clk), .rst(rst), .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
      .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i), .clear_i(clear_i),
      .locked_o(locked_b), .latency_o(lat_b), .bit_ct_o(bit_b), .err_ct_o(err_b), .sat_o(sat_b));

   always #5 clk = ~clk;

   typedef struct { int lock; int lat; int sc; int we; int bc; int ec; int sat; } ms_t;
   typedef struct { logic [63:0] a; logic [63:0] b; } exp_t;

   int total = 0;
   int bad = 0;
   ms_t m16, m4;
   bit refs[$];
   int since = 0;
   logic [6:0] lfsr = 7'h01;
   exp_t sbq[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit hist_at(int k);
      return (k < since) ? refs[refs.size() - 1 - k] : 1'b0;
   endfunction

   function automatic ms_t step(ms_t s, int cw, bit r, bit dv, bit db, bit clr);
      ms_t n = s;
      int mx = (1 << cw) - 1;
      int fill = (since > 64) ? 64 : since;
      int tot;
      bit use_s, mis;
      if (r) begin
         n = '{default: 0};
         return n;
      end
      use_s = dv && (fill > s.lat);
      mis   = db ^ hist_at(s.lat);
      if (clr) begin
         n.bc = 0; n.ec = 0; n.sat = 0;
      end else if (s.lock != 0 && use_s) begin
         if (s.bc < mx) n.bc = s.bc + 1;
         if (mis && s.ec < mx) n.ec = s.ec + 1;
         if (n.bc == mx || n.ec == mx) n.sat = 1;
      end
      if (use_s) begin
         if (s.sc == 31) begin
            tot = s.we + int'(mis);
            n.sc = 0; n.we = 0;
            if (s.lock == 0) begin
               if (tot <= 2) n.lock = 1;
               else n.lat = (s.lat + 1) % 64;
            end else if (tot >= 8) begin
               n.lock = 0;
               n.lat = (s.lat + 1) % 64;
            end
         end else begin
            n.sc = s.sc + 1;
            n.we = s.we + int'(mis);
         end
      end
      return n;
   endfunction

   function automatic logic [63:0] pack(ms_t s);
      logic [15:0] bc = s.bc[15:0];
      logic [15:0] ec = s.ec[15:0];
      logic [5:0]  lt = s.lat[5:0];
      return {24'b0, (s.lock != 0), lt, bc, ec, (s.sat != 0)};
   endfunction

   function automatic logic [63:0] obs_a();
      return {24'b0, locked_a, lat_a, bit_a, err_a, sat_a};
   endfunction

   function automatic logic [63:0] obs_b();
      return {24'b0, locked_b, lat_b, 12'b0, bit_b, 12'b0, err_b, sat_b};
   endfunction

   // One clock: drive, predict, push; then sample after the edge and pop.
   task automatic cycle(input bit r, input bit rv, input bit dv, input bit flip, input bit clr);
      bit rb, db;
      exp_t e;
      rb = lfsr[6] ^ lfsr[5];
      if (rv) lfsr = {lfsr[5:0], rb};
      db = (refs.size() >= 6) ? refs[refs.size() - 6] : 1'b0;
      db = db ^ flip;
      rst = r; ref_valid_i = rv; ref_bit_i = rb;
      dec_valid_i = dv; dec_bit_i = db; clear_i = clr;
      m16 = step(m16, 16, r, dv, db, clr);
      m4  = step(m4, 4, r, dv, db, clr);
      if (r) since = 0;
      else if (rv) begin
         refs.push_back(rb);
         since++;
      end
      sbq.push_back('{a: pack(m16), b: pack(m4)});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk("out_cw16", obs_a(), e.a);
      chk("out_cw4", obs_b(), e.b);
   endtask

   initial begin
      int cyc;
      m16 = '{default: 0};
      m4  = '{default: 0};
      rst = 1'b1; ref_valid_i = 1'b0; ref_bit_i = 1'b0;
      dec_valid_i = 1'b0; dec_bit_i = 1'b0; clear_i = 1'b0;

      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("reset_state", obs_a(), 64'd0);

      cyc = 0;
      while (m16.lock == 0 && cyc < 1000) begin cycle(0, 1, 1, 0, 0); cyc++; end
      chk("first_lock", {locked_a, lat_a}, {1'b1, 6'd5});

      for (int i = 0; i < 1000; i++) cycle(0, 1, 1, 0, 0);
      chk("bits_1000", {bit_a, err_a}, {16'd1000, 16'd0});
      chk("cw4_sat", {bit_b, sat_b}, {4'hf, 1'b1});

      cycle(0, 1, 0, 0, 1);
      chk("clear_cw4", {locked_b, bit_b, sat_b}, {1'b1, 4'h0, 1'b0});
      chk("clear_cw16", {bit_a, err_a}, 32'd0);

      for (int i = 0; i < 800; i++) cycle(0, 1, 1, (i % 8) == 7, 0);
      chk("err_every8", {locked_a, bit_a, err_a}, {1'b1, 16'd800, 16'd100});

      cycle(0, 1, 1, 1, 1);
      chk("clear_vs_err", {bit_a, err_a}, 32'd0);

      cyc = 0;
      while (m16.sc != 0 && cyc < 64) begin cycle(0, 1, 1, 0, 0); cyc++; end
      for (int i = 0; i < 10; i++) cycle(0, 1, 1, 1, 0);
      cyc = 0;
      while (m16.lock != 0 && cyc < 64) begin cycle(0, 1, 1, 0, 0); cyc++; end
      chk("unlock", {locked_a, lat_a}, {1'b0, 6'd6});

      cyc = 0;
      while (m16.lock == 0 && cyc < 3000) begin cycle(0, 1, 1, 0, 0); cyc++; end
      chk("relock_wrap", {locked_a, lat_a}, {1'b1, 6'd5});

      for (int i = 0; i < 40; i++) cycle(0, 1, 1, (i % 16) == 3, 0);
      cycle(1, 0, 0, 0, 0);
      chk("rst_midlock", obs_a(), 64'd0);
      chk("rst_midlock4", obs_b(), 64'd0);

      cyc = 0;
      while (m16.lock == 0 && cyc < 1000) begin cycle(0, 1, 1, 0, 0); cyc++; end
      chk("relock_rst", {locked_a, lat_a}, {1'b1, 6'd5});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
